// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side byte stream of the UART receiver.
// master: drives m_data/m_valid, takes m_ready; slave: the reverse.
interface uart_rx_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 16x oversampling FSM feeding a small byte FIFO.
// Ports: clk, rst_n, rxd in; m (byte stream), level, busy, frame_err, overrun out.
module uart_rx_ctrl #(
  parameter int DIV   = 27,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rxd,
  uart_rx_ctrl_if.master m,
  output logic [4:0]     level,
  output logic           busy,
  output logic           frame_err,
  output logic           overrun
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [4:0]  FULL   = 5'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [1:0]  sync_q;
  logic        rxd_s;
  logic [15:0] div_q;
  logic        tick;

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        push;
  logic        ferr_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [4:0]    cnt_q;
  logic          full, pop, wr;

  assign rxd_s = sync_q[1];
  assign tick  = (div_q == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      div_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      div_q  <= tick ? '0 : div_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // sc counts oversample ticks; in DATA/STOP its 15->0
  // wrap lands on the middle of each bit.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            sc_d    = 4'd1;
          end
        end
        START: begin
          if (sc_q == 4'd8) begin
            sc_d = '0;
            if (!rxd_s) begin
              state_d = DATA;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            sh_d[idx_q] = rxd_s;
            idx_d       = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rxd_s) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  assign m.m_valid = (cnt_q != 5'd0);
  assign m.m_data  = m.m_valid ? mem[rp_q] : 8'h00;
  assign level     = cnt_q;

  assign full = (cnt_q == FULL);
  assign pop  = m.m_valid & m.m_ready;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign wr   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr)  wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 5'd1;
        2'b01:   cnt_q <= cnt_q - 5'd1;
        default: cnt_q <= cnt_q;
      endcase
      frame_err <= ferr_d;
      overrun   <= push & full & ~pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial stimulus with a byte scoreboard.
// Covers normal receive, glitch, break, overrun, full push+pop, reset.
module tb_uart_rx_ctrl;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int BIT   = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [4:0] level;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .m         (u_if),
    .level     (level),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] sb[$];
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int pop_cnt = 0;
  int vld_cnt = 0;
  int f0, o0, p0, v0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    p0 = pop_cnt;
    v0 = vld_cnt;
  endtask

  task automatic send_frame(logic [7:0] b);
    rxd = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(BIT);
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    send_frame(b);
    rxd = 1'b1;
    wait_clk(BIT);
  endtask

  // Monitor: samples mid-cycle, pops scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (u_if.m_valid) vld_cnt++;
        if (u_if.m_valid && u_if.m_ready) begin
          pop_cnt++;
          chk("sb_has", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0)
            chk("pop_data", u_if.m_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    u_if.m_ready = 1'b1;
    rst_n = 1'b0;
    rxd = 1'b1;
    wait_clk(3);
    chk("rst_valid", u_if.m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_data", u_if.m_data, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // plain byte
    snap();
    sb.push_back(8'hA5);
    send_byte(8'hA5);
    wait_clk(16);
    chk("a5_vld_cyc", vld_cnt - v0, 1);
    chk("a5_pops", pop_cnt - p0, 1);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_ovr", ovr_cnt - o0, 0);
    chk("a5_busy", busy, 0);

    // short low glitch
    snap();
    rxd = 1'b0;
    wait_clk(15);
    chk("gl_busy_hi", busy, 1);
    wait_clk(5);
    rxd = 1'b1;
    wait_clk(100);
    chk("gl_busy_lo", busy, 0);
    chk("gl_level", level, 0);
    chk("gl_ferr", ferr_cnt - f0, 0);
    chk("gl_pops", pop_cnt - p0, 0);

    // break: stop bit held low
    snap();
    send_frame(8'h3C);
    rxd = 1'b0;
    wait_clk(190);
    chk("brk_busy_hi", busy, 1);
    chk("brk_ferr_mid", ferr_cnt - f0, 1);
    wait_clk(10);
    rxd = 1'b1;
    wait_clk(BIT);
    chk("brk_busy_lo", busy, 0);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_level", level, 0);
    chk("brk_ovr", ovr_cnt - o0, 0);

    // overrun on fifth byte
    u_if.m_ready = 1'b0;
    snap();
    for (int v = 1; v <= 5; v++) begin
      if (v <= DEPTH) sb.push_back(8'(v));
      send_byte(8'(v));
    end
    wait_clk(16);
    chk("ovr_level", level, 4);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_ferr", ferr_cnt - f0, 0);
    chk("ovr_valid", u_if.m_valid, 1);
    u_if.m_ready = 1'b1;
    wait_clk(8);
    u_if.m_ready = 1'b0;
    chk("ovr_drain_lvl", level, 0);
    chk("ovr_drain_pops", pop_cnt - p0, 4);
    chk("ovr_sb", sb.size(), 0);

    // full FIFO, pop coincides with push
    for (int v = 1; v <= 4; v++) begin
      sb.push_back(8'(v));
      send_byte(8'(v));
    end
    snap();
    sb.push_back(8'h05);
    fork
      send_byte(8'h05);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!dut.push && n < 2000);
        chk("pp_push_seen", dut.push, 1);
        u_if.m_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.m_ready = 1'b0;
      end
    join
    wait_clk(16);
    chk("pp_level", level, 4);
    chk("pp_ovr", ovr_cnt - o0, 0);
    chk("pp_pops", pop_cnt - p0, 1);
    u_if.m_ready = 1'b1;
    wait_clk(8);
    u_if.m_ready = 1'b0;
    chk("pp_drain_lvl", level, 0);
    chk("pp_sb", sb.size(), 0);

    // reset mid-frame with bytes queued
    sb.push_back(8'h11);
    send_byte(8'h11);
    sb.push_back(8'h22);
    send_byte(8'h22);
    wait_clk(8);
    chk("rs_level_pre", level, 2);
    fork
      send_byte(8'h5A);
      begin
        wait_clk(BIT * 5 + 32);
        rst_n = 1'b0;
        #1;
        chk("rs_level", level, 0);
        chk("rs_valid", u_if.m_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_data", u_if.m_data, 0);
      end
    join
    wait_clk(4);
    sb.delete();
    rst_n = 1'b1;
    wait_clk(10);
    snap();
    u_if.m_ready = 1'b1;
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    wait_clk(16);
    chk("c3_pops", pop_cnt - p0, 1);
    chk("c3_level", level, 0);
    chk("c3_ferr", ferr_cnt - f0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DIV, default 27: clk cycles per oversample tick (16 ticks per bit); legal range 2..65535.
REQ-002 Parameter DEPTH, default 4: RX FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rxd  input  1  asynchronous serial line, idle high.
REQ-006 m_data  output  8  FIFO head byte; valid only while m_valid=1.
REQ-007 m_valid  output  1  FIFO non-empty.
REQ-008 m_ready  input  1  consumer accepts m_data when m_valid&m_ready.
REQ-009 level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-010 busy  output  1  high whenever FSM state is not IDLE.
REQ-011 frame_err  output  1  one-clk pulse per stop-bit failure.
REQ-012 overrun  output  1  one-clk pulse per good byte dropped because FIFO full.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); FSM sees only synchronized rxd_s.
REQ-014 Tick divider: free-running counter 0..DIV-1; tick = 1 for one clk when counter==DIV-1, then wraps to 0.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; all transitions occur only on tick cycles.
REQ-016 IDLE: on tick with rxd_s==0 -> START, sample counter sc=1; otherwise stay.
REQ-017 START: sc increments each tick; on the tick where sc==8, rxd_s==0 -> DATA with sc=0, bit index=0; rxd_s==1 -> IDLE (glitch rejected, no flag).
REQ-018 DATA: sc increments each tick mod 16; on the tick where sc wraps 15->0, rxd_s is shifted into shift register LSB-first at bit index; after bit 7 -> STOP.
REQ-019 STOP: on 16th tick, rxd_s==1 -> byte pushed (or dropped, REQ-022), -> IDLE; rxd_s==0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until tick with rxd_s==1, then -> IDLE; break conditions produce exactly one frame_err.
REQ-021 Push latency: byte visible on m_data with m_valid=1 on the clk after the stop-sample tick.
REQ-022 Push while level==DEPTH and no pop same cycle: byte dropped, FIFO unchanged, overrun pulses 1 clk.
REQ-023 Push and pop in same cycle while full: both performed, level stays DEPTH, no overrun.
REQ-024 Push and pop in same cycle while not full and not empty: level unchanged, order preserved.
REQ-025 Pop with m_valid=0 SHALL be ignored; level never underflows.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; m_data is FIFO order (first received, first out).
REQ-027 frame_err and overrun SHALL never assert in the same cycle for the same frame.

Reset
REQ-028 On rst_n low, asynchronously: FSM=IDLE, divider=0, sc=0, shift reg=0, FIFO pointers/level=0, synchronizer=1.
REQ-029 Outputs during and after reset: m_valid=0, level=0, busy=0, frame_err=0, overrun=0, m_data=0.
REQ-030 Reset mid-frame SHALL discard the partial byte and all FIFO contents; reception resumes on the next falling edge after release.

Verification (DIV=4, DEPTH=4, bit period 64 clk)
REQ-031 Send 0xA5, 8N1, m_ready=1 -> m_valid 1 clk high, m_data=0xA5, frame_err=0, overrun=0, busy low after stop.
REQ-032 rxd low for 20 clk then high, idle -> FSM returns IDLE at START mid-check, no push, no flags, level=0.
REQ-033 Send 0x3C with stop bit held low 200 clk -> exactly one frame_err pulse, level=0, busy high until rxd high.
REQ-034 m_ready=0, send 0x01..0x05 -> level=4, one overrun pulse on fifth byte; then pop 4 -> 0x01,0x02,0x03,0x04.
REQ-035 FIFO full, pop asserted on 5th byte's push cycle -> no overrun, level=4, pop sequence 0x02..0x05.
REQ-036 Assert rst_n low during bit 4 of 0x5A with 2 bytes queued -> level=0, m_valid=0 immediately; next frame 0xC3 received correctly.
